// File: rtl/hilo_mult_unit.sv
// HI/LO multiply/accumulate unit: radix-2 shift-add multiplier (WIDTH cycles)
// owning the architectural HI/LO registers and the MUL result register.
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [5:0]       ALUcnt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MulResult,
    output logic [WIDTH-1:0] HiLoOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [5:0] OP_MUL   = 6'b000010;
    localparam logic [5:0] OP_MULTU = 6'b000011;
    localparam logic [5:0] OP_MADD  = 6'b000100;
    localparam logic [5:0] OP_MSUB  = 6'b000101;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MTHI  = 6'b010100;
    localparam logic [5:0] OP_MTLO  = 6'b010101;
    localparam logic [5:0] OP_MFHI  = 6'b010110;
    localparam logic [5:0] OP_MFLO  = 6'b010111;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [5:0]         r_op;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mulres;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_is_mult;
    logic               w_is_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [2*WIDTH-1:0] w_final;

    // Operation decode, operand magnitudes and the next partial product
    always_comb begin
        w_is_mult   = 1'b0;
        w_is_signed = 1'b0;
        case (ALUcnt)
            OP_MUL, OP_MADD, OP_MSUB, OP_MULT: begin
                w_is_mult   = 1'b1;
                w_is_signed = 1'b1;
            end
            OP_MULTU: begin
                w_is_mult   = 1'b1;
                w_is_signed = 1'b0;
            end
            default: begin
                w_is_mult   = 1'b0;
                w_is_signed = 1'b0;
            end
        endcase
        // Start is only honoured outside RUN, and Flush always suppresses it.
        w_accept = Start & ~Flush & (r_state != ST_RUN);
        // Negating the most negative value yields its unsigned magnitude.
        w_abs_a = (w_is_signed && A[WIDTH-1]) ? -A : A;
        w_abs_b = (w_is_signed && B[WIDTH-1]) ? -B : B;
        w_prod_next = r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
        w_final     = r_neg ? -w_prod_next : w_prod_next;
    end

    // Combinational HI/LO read port for MFHI/MFLO
    always_comb begin
        case (ALUcnt)
            OP_MFHI: HiLoOut = r_hi;
            OP_MFLO: HiLoOut = r_lo;
            default: HiLoOut = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM, shift-add datapath and architectural register writes
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 6'b000000;
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_neg    <= 1'b0;
            r_prod   <= {(2*WIDTH){1'b0}};
            r_count  <= {CW{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_mulres <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (Flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_prod   <= w_prod_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + {{(CW-1){1'b0}}, 1'b1};
                        if (r_count == LAST_COUNT) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            case (r_op)
                                OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_final;
                                OP_MADD:           {r_hi, r_lo} <= {r_hi, r_lo} + w_final;
                                OP_MSUB:           {r_hi, r_lo} <= {r_hi, r_lo} - w_final;
                                OP_MUL:            r_mulres     <= w_final[WIDTH-1:0];
                                default:           r_mulres     <= r_mulres;
                            endcase
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        if (w_is_mult) begin
                            r_op     <= ALUcnt;
                            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_mplier <= w_abs_b;
                            r_neg    <= w_is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_prod   <= {(2*WIDTH){1'b0}};
                            r_count  <= {CW{1'b0}};
                            r_state  <= ST_RUN;
                            r_busy   <= 1'b1;
                        end else begin
                            case (ALUcnt)
                                OP_MTHI: r_hi <= A;
                                OP_MTLO: r_lo <= A;
                                default: r_lo <= r_lo;
                            endcase
                        end
                    end else begin
                        r_op <= r_op;
                    end
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign MulResult = r_mulres;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

endmodule
